ped_crossing_ctrl: RTL and testbench

- Downstream consumer of the vehicle traffic-light controller's 2-bit lamp code.
- Latches pedestrian push-button requests and grants a WALK interval only at the start of a vehicle red phase.
- After WALK, runs a flashing DON'T WALK clearance with countdown, then holds steady DON'T WALK until red ends.
- Drives the pedestrian lamps and a sticky safety fault flag.

---
 rtl/traffic_pkg.sv | 17 +
 rtl/btn_sync_edge.sv | 36 +++
 rtl/ped_crossing_ctrl.sv | 157 +++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light and pedestrian crossing blocks.
package traffic_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RED = 3'd1,
    WALK     = 3'd2,
    CLEAR    = 3'd3,
    HOLD     = 3'd4
  } ped_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a one-cycle
// rising-edge pulse; reusable for any slow sensor input.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Shift the raw input through the synchronizer and keep one history bit.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests, grants WALK only
// at the start of a vehicle red phase, then runs a flashing clearance with
// countdown and a steady DON'T WALK hold until red ends.
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYC  = 4,
  parameter int CLEAR_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] light,
  input  logic       btn,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYC - 1);
  localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_CYC - 1);
  localparam logic [3:0] CLEAR_INIT = 4'(CLEAR_CYC);

  ped_state_t state_q, state_d;
  logic [1:0] light_q, light_d;
  logic [3:0] cnt_q, cnt_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic [3:0] countdown_q, countdown_d;
  logic       req_pending_q, req_pending_d;
  logic       fault_q, fault_d;

  logic btn_rise;
  logic red_now;
  logic red_entry;
  logic pending;

  btn_sync_edge u_btn_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (btn),
    .rise (btn_rise)
  );

  assign red_now   = (light == LIGHT_RED);
  assign red_entry = red_now && (light_q != LIGHT_RED);
  assign pending   = req_pending_q | btn_rise;

  // Next-state and next-output logic; illegal codes and red ending during
  // WALK/CLEAR override normal sequencing and force a safe DON'T WALK.
  always_comb begin
    state_d       = state_q;
    light_d       = light;
    cnt_d         = cnt_q;
    walk_d        = walk_q;
    dont_walk_d   = dont_walk_q;
    countdown_d   = countdown_q;
    req_pending_d = pending;
    fault_d       = fault_q;

    if (light == LIGHT_ILLEGAL ||
        ((state_q == WALK || state_q == CLEAR) && !red_now)) begin
      fault_d     = 1'b1;
      walk_d      = 1'b0;
      dont_walk_d = 1'b1;
      countdown_d = 4'd0;
      cnt_d       = 4'd0;
      state_d     = pending ? WAIT_RED : IDLE;
    end else begin
      case (state_q)
        IDLE, WAIT_RED: begin
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          countdown_d = 4'd0;
          if (red_entry && pending) begin
            state_d       = WALK;
            walk_d        = 1'b1;
            dont_walk_d   = 1'b0;
            cnt_d         = WALK_LOAD;
            req_pending_d = 1'b0;
          end else if (pending) begin
            state_d = WAIT_RED;
          end
        end
        WALK: begin
          if (cnt_q == 4'd0) begin
            state_d     = CLEAR;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            countdown_d = CLEAR_INIT;
            cnt_d       = CLEAR_LOAD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        CLEAR: begin
          if (cnt_q == 4'd0) begin
            state_d     = HOLD;
            dont_walk_d = 1'b1;
            countdown_d = 4'd0;
          end else begin
            dont_walk_d = ~dont_walk_q;
            countdown_d = countdown_q - 4'd1;
            cnt_d       = cnt_q - 4'd1;
          end
        end
        HOLD: begin
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          countdown_d = 4'd0;
          if (!red_now) begin
            state_d = pending ? WAIT_RED : IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          walk_d      = 1'b0;
          dont_walk_d = 1'b1;
          countdown_d = 4'd0;
          cnt_d       = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; light_q resets to red so the red phase
  // present at reset release is never treated as a red entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      light_q       <= LIGHT_RED;
      cnt_q         <= 4'd0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      countdown_q   <= 4'd0;
      req_pending_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      light_q       <= light_d;
      cnt_q         <= cnt_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      countdown_q   <= countdown_d;
      req_pending_q <= req_pending_d;
      fault_q       <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = countdown_q;
  assign req_pending = req_pending_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: a behavioural model tracks the
// time since the last grant and derives lamp outputs from it.
module tb_ped_crossing_ctrl;

  localparam int W = 4;
  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [1:0] light;
  logic       btn;
  logic       walk;
  logic       dont_walk;
  logic [3:0] countdown;
  logic       req_pending;
  logic       fault;

  int checks;
  int passes;
  bit run_cmp;

  ped_crossing_ctrl #(.WALK_CYC(W), .CLEAR_CYC(C)) dut (
    .clk         (clk),
    .rst         (rst),
    .light       (light),
    .btn         (btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .fault       (fault)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: m_age is cycles since the grant, -1 when not serving.
  int         m_age;
  bit         m_pend;
  bit         m_fault;
  logic [1:0] m_lprev;
  bit         m_s1, m_s2, m_s3;
  bit         m_rise;
  bit         m_red_entry;

  // Behavioural model stepped on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age   = -1;
      m_pend  = 0;
      m_fault = 0;
      m_lprev = 2'b00;
      m_s1    = 0;
      m_s2    = 0;
      m_s3    = 0;
    end else begin
      m_rise      = m_s2 & ~m_s3;
      m_s3        = m_s2;
      m_s2        = m_s1;
      m_s1        = btn;
      m_red_entry = (light == 2'b00) && (m_lprev != 2'b00);
      if (light == 2'b11) begin
        m_fault = 1;
        m_age   = -1;
        m_pend  = m_pend | m_rise;
      end else if (m_age >= 0 && m_age < W + C && light != 2'b00) begin
        m_fault = 1;
        m_age   = -1;
        m_pend  = m_pend | m_rise;
      end else if (m_age >= 0) begin
        if (light != 2'b00) m_age = -1;
        else if (m_age < W + C) m_age = m_age + 1;
        m_pend = m_pend | m_rise;
      end else if (m_red_entry && (m_pend || m_rise)) begin
        m_age  = 0;
        m_pend = 0;
      end else begin
        m_pend = m_pend | m_rise;
      end
      m_lprev = light;
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      bit in_walk, in_clr;
      int e_dw, e_cd;
      in_walk = (m_age >= 0) && (m_age < W);
      in_clr  = (m_age >= W) && (m_age < W + C);
      e_dw    = in_walk ? 0 : (in_clr ? (((m_age - W) % 2) == 0 ? 1 : 0) : 1);
      e_cd    = in_clr ? (C - (m_age - W)) : 0;
      checkOutput("model_walk", int'(walk), in_walk ? 1 : 0);
      checkOutput("model_dont_walk", int'(dont_walk), e_dw);
      checkOutput("model_countdown", int'(countdown), e_cd);
      checkOutput("model_req_pending", int'(req_pending), m_pend ? 1 : 0);
      checkOutput("model_fault", int'(fault), m_fault ? 1 : 0);
      checkOutput("walk_dw_exclusive", int'(walk & dont_walk), 0);
    end
  end

  task automatic applyStimulus(input logic [1:0] l, input logic b, input int n);
    light = l;
    btn   = b;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed scenario sequence with hand-computed literal expectations.
  initial begin
    checks  = 0;
    passes  = 0;
    run_cmp = 0;
    light   = 2'b00;
    btn     = 1'b0;
    rst     = 1'b1;
    #1;
    applyReset();
    run_cmp = 1;
    checkOutput("reset_walk", int'(walk), 0);
    checkOutput("reset_dont_walk", int'(dont_walk), 1);
    checkOutput("reset_countdown", int'(countdown), 0);
    checkOutput("reset_req", int'(req_pending), 0);
    checkOutput("reset_fault", int'(fault), 0);

    $display("[TB] idle cycle with no button");
    applyStimulus(2'b00, 0, 10);
    applyStimulus(2'b01, 0, 8);
    applyStimulus(2'b10, 0, 5);
    checkOutput("idle_walk", int'(walk), 0);
    checkOutput("idle_fault", int'(fault), 0);

    $display("[TB] press during green, full walk/clear sequence");
    applyStimulus(2'b01, 1, 2);
    checkOutput("req_not_yet", int'(req_pending), 0);
    applyStimulus(2'b01, 0, 1);
    checkOutput("req_after_3_edges", int'(req_pending), 1);
    applyStimulus(2'b01, 0, 2);
    applyStimulus(2'b00, 0, 1);
    checkOutput("grant_walk", int'(walk), 1);
    checkOutput("grant_dont_walk", int'(dont_walk), 0);
    checkOutput("grant_req_clear", int'(req_pending), 0);
    applyStimulus(2'b00, 0, 3);
    checkOutput("walk_4th_cycle", int'(walk), 1);
    applyStimulus(2'b00, 0, 1);
    checkOutput("clr1_walk", int'(walk), 0);
    checkOutput("clr1_dw", int'(dont_walk), 1);
    checkOutput("clr1_cd", int'(countdown), 4);
    applyStimulus(2'b00, 0, 1);
    checkOutput("clr2_dw", int'(dont_walk), 0);
    checkOutput("clr2_cd", int'(countdown), 3);
    applyStimulus(2'b00, 0, 2);
    checkOutput("clr4_dw", int'(dont_walk), 0);
    checkOutput("clr4_cd", int'(countdown), 1);
    applyStimulus(2'b00, 0, 1);
    checkOutput("hold_dw", int'(dont_walk), 1);
    checkOutput("hold_cd", int'(countdown), 0);
    applyStimulus(2'b00, 0, 1);

    $display("[TB] press during walk served at next red entry");
    applyStimulus(2'b01, 1, 2);
    applyStimulus(2'b01, 0, 6);
    applyStimulus(2'b00, 0, 1);
    checkOutput("grant2_walk", int'(walk), 1);
    applyStimulus(2'b00, 1, 2);
    applyStimulus(2'b00, 0, 7);
    checkOutput("no_regrant_walk", int'(walk), 0);
    checkOutput("no_regrant_req", int'(req_pending), 1);
    applyStimulus(2'b10, 0, 3);
    applyStimulus(2'b00, 0, 1);
    checkOutput("grant3_walk", int'(walk), 1);
    checkOutput("grant3_req", int'(req_pending), 0);
    applyStimulus(2'b00, 0, 9);

    $display("[TB] button held through reset release in red");
    light = 2'b00;
    btn   = 1'b1;
    applyReset();
    applyStimulus(2'b00, 1, 10);
    checkOutput("first_red_no_grant", int'(walk), 0);
    checkOutput("first_red_req", int'(req_pending), 1);
    applyStimulus(2'b01, 0, 3);
    applyStimulus(2'b00, 0, 1);
    checkOutput("later_red_grant", int'(walk), 1);
    applyStimulus(2'b00, 0, 9);

    $display("[TB] safety abort on 2nd walk cycle");
    applyStimulus(2'b01, 1, 2);
    applyStimulus(2'b01, 0, 4);
    applyStimulus(2'b00, 0, 2);
    applyStimulus(2'b01, 0, 1);
    checkOutput("abort_walk", int'(walk), 0);
    checkOutput("abort_dw", int'(dont_walk), 1);
    checkOutput("abort_cd", int'(countdown), 0);
    checkOutput("abort_fault", int'(fault), 1);
    applyStimulus(2'b01, 0, 4);
    applyStimulus(2'b10, 0, 3);
    applyStimulus(2'b00, 0, 5);
    checkOutput("fault_sticky", int'(fault), 1);
    light = 2'b00;
    btn   = 1'b0;
    applyReset();
    checkOutput("fault_cleared", int'(fault), 0);

    $display("[TB] illegal code while waiting for red");
    applyStimulus(2'b01, 1, 2);
    applyStimulus(2'b01, 0, 3);
    applyStimulus(2'b11, 0, 1);
    checkOutput("illegal_fault", int'(fault), 1);
    checkOutput("illegal_req", int'(req_pending), 1);
    checkOutput("illegal_walk", int'(walk), 0);
    applyStimulus(2'b00, 0, 1);
    checkOutput("red_after_illegal_walk", int'(walk), 1);
    checkOutput("red_after_illegal_req", int'(req_pending), 0);
    applyStimulus(2'b00, 0, 9);

    @(posedge clk);
    run_cmp = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
